// File: rtl/reg_file_sb.sv
// Two-write/two-read register file with an issue/writeback busy-bit scoreboard.
// Latency: writes and scoreboard update on one edge; reads and hazard flags are combinational.
// Backpressure: iss_stall refuses an issue to a still-busy destination (WAW); requester holds.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en0,
   input  logic [AW-1:0]   wr_addr0,
   input  logic [XLEN-1:0] wr_data0,
   input  logic            wr_en1,
   input  logic [AW-1:0]   wr_addr1,
   input  logic [XLEN-1:0] wr_data1,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rd_data1,
   output logic [XLEN-1:0] rd_data2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_stall,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]     busy_count_q, busy_count_d;

   logic we0, we1;
   logic rs1_wr_hit, rs2_wr_hit, iss_wr_hit;
   logic iss_accept;

   // Decode write-port qualifiers and same-cycle address matches.
   always_comb begin
      we0        = wr_en0 && !(ZERO_REG != 0 && wr_addr0 == '0);
      we1        = wr_en1 && !(ZERO_REG != 0 && wr_addr1 == '0);
      rs1_wr_hit = (wr_en0 && wr_addr0 == rs1) || (wr_en1 && wr_addr1 == rs1);
      rs2_wr_hit = (wr_en0 && wr_addr0 == rs2) || (wr_en1 && wr_addr1 == rs2);
      iss_wr_hit = (wr_en0 && wr_addr0 == iss_rd) || (wr_en1 && wr_addr1 == iss_rd);
   end

   // Register array; port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         if (we0) regs_q[wr_addr0] <= wr_data0;
         if (we1) regs_q[wr_addr1] <= wr_data1;
      end
   end

   // Read port 1: array value, optionally forwarded from a same-cycle write (port 1 first).
   always_comb begin
      rd_data1 = regs_q[rs1];
      if (BYPASS != 0) begin
         if (wr_en0 && wr_addr0 == rs1) rd_data1 = wr_data0;
         if (wr_en1 && wr_addr1 == rs1) rd_data1 = wr_data1;
      end
      // Forwarded data must not leak out while reset is held.
      if (rst || (ZERO_REG != 0 && rs1 == '0)) rd_data1 = '0;
   end

   // Read port 2: same structure as read port 1.
   always_comb begin
      rd_data2 = regs_q[rs2];
      if (BYPASS != 0) begin
         if (wr_en0 && wr_addr0 == rs2) rd_data2 = wr_data0;
         if (wr_en1 && wr_addr1 == rs2) rd_data2 = wr_data1;
      end
      if (rst || (ZERO_REG != 0 && rs2 == '0)) rd_data2 = '0;
   end

   // Hazard flags: a source stops being busy in the writeback cycle only when forwarding exists.
   always_comb begin
      rs1_busy   = busy_q[rs1] && !(BYPASS != 0 && rs1_wr_hit) && !(ZERO_REG != 0 && rs1 == '0);
      rs2_busy   = busy_q[rs2] && !(BYPASS != 0 && rs2_wr_hit) && !(ZERO_REG != 0 && rs2 == '0);
      // A writeback to the destination this cycle retires the older producer, so no WAW stall.
      iss_stall  = iss_valid && busy_q[iss_rd] && !iss_wr_hit;
      iss_accept = iss_valid && !iss_stall && !(ZERO_REG != 0 && iss_rd == '0);
   end

   // Next busy vector: clears from writeback first, then the issue set so set wins on overlap.
   always_comb begin
      busy_d = busy_q;
      if (wr_en0) busy_d[wr_addr0] = 1'b0;
      if (wr_en1) busy_d[wr_addr1] = 1'b0;
      if (iss_accept) busy_d[iss_rd] = 1'b1;
      busy_count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   // Scoreboard state and its popcount move together on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build, a no-bypass build and a no-zero-register build
// share one set of inputs so the parameter-dependent behaviour is checked side by side.
module tb_reg_file_sb;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en0, wr_en1, iss_valid;
   logic [AW-1:0]   wr_addr0, wr_addr1, rs1, rs2, iss_rd;
   logic [XLEN-1:0] wr_data0, wr_data1;

   logic [XLEN-1:0] d_rd1, d_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
   logic            d_b1, d_b2, b_b1, b_b2, z_b1, z_b2;
   logic            d_stall, b_stall, z_stall;
   logic [AW:0]     d_cnt, b_cnt, z_cnt;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   reg_file_sb u_dut (
      .clk(clk), .rst(rst),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rs1(rs1), .rs2(rs2), .rd_data1(d_rd1), .rd_data2(d_rd2),
      .rs1_busy(d_b1), .rs2_busy(d_b2),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(d_stall), .busy_count(d_cnt)
   );

   reg_file_sb #(.BYPASS(0)) u_nb (
      .clk(clk), .rst(rst),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rs1(rs1), .rs2(rs2), .rd_data1(b_rd1), .rd_data2(b_rd2),
      .rs1_busy(b_b1), .rs2_busy(b_b2),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(b_stall), .busy_count(b_cnt)
   );

   reg_file_sb #(.ZERO_REG(0)) u_nz (
      .clk(clk), .rst(rst),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rs1(rs1), .rs2(rs2), .rd_data1(z_rd1), .rd_data2(z_rd2),
      .rs1_busy(z_b1), .rs2_busy(z_b2),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(z_stall), .busy_count(z_cnt)
   );

   task automatic idle;
      wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
      wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   // Advance to just after the next rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      // Fill every register with a pattern, mark two busy, then reset mid-cycle.
      for (int i = 0; i < 16; i++) begin
         wr_en0 = 1'b1; wr_addr0 = AW'(2*i);   wr_data0 = 32'hA5A5A5A5;
         wr_en1 = 1'b1; wr_addr1 = AW'(2*i+1); wr_data1 = 32'hA5A5A5A5;
         step;
      end
      idle;
      iss_valid = 1'b1; iss_rd = 5'd4; step;
      iss_valid = 1'b1; iss_rd = 5'd7; step;
      idle; rs1 = 5'd4; rs2 = 5'd0;
      #1;
      vec++; if (d_cnt !== 6'd2) begin errs++; $display("FAIL fill_cnt: got %0d expected 2", d_cnt); end
      vec++; if (d_rd1 !== 32'hA5A5A5A5) begin errs++; $display("FAIL fill_rd: got %h expected a5a5a5a5", d_rd1); end
      vec++; if (d_rd2 !== 32'h0) begin errs++; $display("FAIL zero_reg_rd: got %h expected 0", d_rd2); end
      vec++; if (z_rd2 !== 32'hA5A5A5A5) begin errs++; $display("FAIL nz_reg0_rd: got %h expected a5a5a5a5", z_rd2); end
      // Mid-cycle reset with a write and issue pending on the same cycle.
      rs2 = 5'd7;
      wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h77;
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1 rst = 1'b1;
      #1;
      vec++; if (d_rd1 !== 32'h0) begin errs++; $display("FAIL rst_rd1: got %h expected 0", d_rd1); end
      vec++; if (d_rd2 !== 32'h0) begin errs++; $display("FAIL rst_rd2: got %h expected 0", d_rd2); end
      vec++; if (d_cnt !== 6'd0) begin errs++; $display("FAIL rst_cnt: got %0d expected 0", d_cnt); end
      vec++; if ({d_b1, d_b2} !== 2'b00) begin errs++; $display("FAIL rst_busy: got %b expected 00", {d_b1, d_b2}); end
      step;
      idle;
      rst = 1'b0;
      #1;
      vec++; if (d_rd1 !== 32'h0) begin errs++; $display("FAIL rst_discard_wr: got %h expected 0", d_rd1); end
      vec++; if (d_cnt !== 6'd0) begin errs++; $display("FAIL rst_discard_iss: got %0d expected 0", d_cnt); end
   endtask

   task automatic test_bypass;
      step;
      wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h1234; rs1 = 5'd5;
      #1;
      vec++; if (d_rd1 !== 32'h1234) begin errs++; $display("FAIL bypass_same: got %h expected 1234", d_rd1); end
      vec++; if (b_rd1 !== 32'h0) begin errs++; $display("FAIL nobypass_old: got %h expected 0", b_rd1); end
      step;
      idle;
      #1;
      vec++; if (d_rd1 !== 32'h1234) begin errs++; $display("FAIL bypass_held: got %h expected 1234", d_rd1); end
      vec++; if (b_rd1 !== 32'h1234) begin errs++; $display("FAIL nobypass_new: got %h expected 1234", b_rd1); end
   endtask

   task automatic test_dual_write;
      wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
      wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22;
      rs1 = 5'd7;
      #1;
      vec++; if (d_rd1 !== 32'h22) begin errs++; $display("FAIL dual_bypass_prio: got %h expected 22", d_rd1); end
      step;
      idle;
      #1;
      vec++; if (d_rd1 !== 32'h22) begin errs++; $display("FAIL dual_store: got %h expected 22", d_rd1); end
      vec++; if (b_rd1 !== 32'h22) begin errs++; $display("FAIL dual_store_nb: got %h expected 22", b_rd1); end
      wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hDEAD; rs2 = 5'd0;
      #1;
      vec++; if (d_rd2 !== 32'h0) begin errs++; $display("FAIL zero_bypass: got %h expected 0", d_rd2); end
      vec++; if (z_rd2 !== 32'hDEAD) begin errs++; $display("FAIL nz_bypass: got %h expected dead", z_rd2); end
      step;
      idle;
      #1;
      vec++; if (d_rd2 !== 32'h0) begin errs++; $display("FAIL zero_store: got %h expected 0", d_rd2); end
      vec++; if (z_rd2 !== 32'hDEAD) begin errs++; $display("FAIL nz_store: got %h expected dead", z_rd2); end
   endtask

   task automatic test_scoreboard;
      iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
      #1;
      vec++; if (d_stall !== 1'b0) begin errs++; $display("FAIL iss_first_stall: got %b expected 0", d_stall); end
      step;
      idle;
      #1;
      vec++; if (d_cnt !== 6'd1) begin errs++; $display("FAIL iss_cnt: got %0d expected 1", d_cnt); end
      vec++; if (d_b2 !== 1'b1) begin errs++; $display("FAIL iss_rs2_busy: got %b expected 1", d_b2); end
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1;
      vec++; if (d_stall !== 1'b1) begin errs++; $display("FAIL waw_stall: got %b expected 1", d_stall); end
      step;
      idle;
      #1;
      vec++; if (d_cnt !== 6'd1) begin errs++; $display("FAIL stall_cnt: got %0d expected 1", d_cnt); end
      wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h99;
      #1;
      vec++; if (d_b2 !== 1'b0) begin errs++; $display("FAIL wb_rs2_busy: got %b expected 0", d_b2); end
      vec++; if (b_b2 !== 1'b1) begin errs++; $display("FAIL wb_rs2_busy_nb: got %b expected 1", b_b2); end
      step;
      idle;
      #1;
      vec++; if (d_cnt !== 6'd0) begin errs++; $display("FAIL wb_cnt: got %0d expected 0", d_cnt); end
      vec++; if (b_b2 !== 1'b0) begin errs++; $display("FAIL wb_next_nb: got %b expected 0", b_b2); end
      vec++; if (d_rd2 !== 32'h99) begin errs++; $display("FAIL wb_data: got %h expected 99", d_rd2); end
   endtask

   task automatic test_same_edge;
      iss_valid = 1'b1; iss_rd = 5'd3;
      step;
      idle;
      iss_valid = 1'b1; iss_rd = 5'd3;
      wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h33;
      #1;
      vec++; if (d_stall !== 1'b0) begin errs++; $display("FAIL same_edge_stall: got %b expected 0", d_stall); end
      step;
      idle; rs1 = 5'd3;
      #1;
      vec++; if (d_cnt !== 6'd1) begin errs++; $display("FAIL same_edge_cnt: got %0d expected 1", d_cnt); end
      vec++; if (d_b1 !== 1'b1) begin errs++; $display("FAIL same_edge_busy: got %b expected 1", d_b1); end
      vec++; if (d_rd1 !== 32'h33) begin errs++; $display("FAIL same_edge_data: got %h expected 33", d_rd1); end
      wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h34;
      step;
      idle;
      #1;
      vec++; if (d_cnt !== 6'd0) begin errs++; $display("FAIL same_edge_clear: got %0d expected 0", d_cnt); end
   endtask

   task automatic test_full;
      for (int i = 0; i < 32; i++) begin
         iss_valid = 1'b1; iss_rd = AW'(i);
         step;
      end
      idle;
      #1;
      vec++; if (z_cnt !== 6'd32) begin errs++; $display("FAIL full_cnt_nz: got %0d expected 32", z_cnt); end
      vec++; if (d_cnt !== 6'd31) begin errs++; $display("FAIL full_cnt_zero: got %0d expected 31", d_cnt); end
      iss_valid = 1'b1; iss_rd = 5'd17;
      #1;
      vec++; if (z_stall !== 1'b1) begin errs++; $display("FAIL full_stall_nz: got %b expected 1", z_stall); end
      iss_rd = 5'd0; rs1 = 5'd0;
      #1;
      vec++; if (z_stall !== 1'b1) begin errs++; $display("FAIL full_stall_r0_nz: got %b expected 1", z_stall); end
      vec++; if (d_stall !== 1'b0) begin errs++; $display("FAIL r0_stall: got %b expected 0", d_stall); end
      vec++; if ({d_b1, z_b1} !== 2'b01) begin errs++; $display("FAIL r0_busy: got %b expected 01", {d_b1, z_b1}); end
      step;
      idle;
      #1;
      vec++; if (d_cnt !== 6'd31) begin errs++; $display("FAIL r0_no_set: got %0d expected 31", d_cnt); end
      vec++; if (z_cnt !== 6'd32) begin errs++; $display("FAIL full_no_wrap: got %0d expected 32", z_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      idle;
      rs1 = '0; rs2 = '0;
      step;
      step;
      rst = 1'b0;
      test_reset;
      test_bypass;
      test_dual_write;
      test_scoreboard;
      test_same_edge;
      test_full;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
